cnn_result_tx: RTL and testbench

Return path of the CNN accelerator. Collects the 1-bit output stream of `cnn_core` and packs it LSB-first into bytes in a local buffer, the inverse of the input-side unpacking. Once a whole frame is buffered, it sends a framed response (header, length, payload, XOR checksum) through the UART transmitter's `trmt`/`tx_done` handshake. It sits between `cnn_core` and the UART TX port of the top level.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/ram.sv | 21 ++
 rtl/cnn_result_tx.sv | 146 ++++++++++++++
 tb/tb_cnn_result_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator return path.
package cnn_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    FLUSH   = 3'd1,
    FETCH   = 3'd2,
    SEND    = 3'd3,
    WAIT    = 3'd4
  } state_tx_t;

  localparam logic [7:0] CNN_HDR = 8'hA5;

endpackage

// File: rtl/ram.sv
// Simple dual-port buffer: synchronous write, registered read (1-cycle latency).
module ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/cnn_result_tx.sv
// Packs the core's 1-bit result stream into bytes and ships a framed
// response (HDR, len, payload, XOR checksum) over the UART trmt/tx_done handshake.
module cnn_result_tx
  import cnn_pkg::*;
#(
  parameter int         MAX_BYTES = 128,
  parameter logic [7:0] HDR       = CNN_HDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_vld,
  input  logic       bit_in,
  input  logic       bit_last,
  output logic       bit_rdy,
  output logic       trmt,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       ovf,
  output logic       frame_sent
);

  localparam int         AW   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [7:0] MAXB = 8'(MAX_BYTES);

  state_tx_t   r_state;
  logic [2:0]  r_bcnt;
  logic [7:0]  r_wptr, r_len, r_csum, r_shift, r_tx_data;
  logic [8:0]  r_idx;
  logic        r_trmt, r_ovf, r_ovf_frm;

  logic          w_full, w_we;
  logic [7:0]    w_wdata, w_rdata, w_sel;
  logic [8:0]    w_len2;
  logic [AW-1:0] w_waddr, w_raddr;

  assign w_full  = (r_wptr == MAXB);
  assign w_len2  = {1'b0, r_len} + 9'd2;
  assign w_waddr = r_wptr[AW-1:0];
  // Payload byte n lives at ram[n]; idx 0/1 are header and length.
  assign w_raddr = AW'(r_idx - 9'd2);

  always_comb begin
    w_we    = 1'b0;
    w_wdata = r_shift;
    if (r_state == COLLECT && bit_vld && !w_full && r_bcnt == 3'd7) begin
      w_we    = 1'b1;
      w_wdata = {bit_in, r_shift[6:0]};
    end else if (r_state == FLUSH && r_bcnt != 3'd0 && !w_full) begin
      w_we    = 1'b1;
    end
  end

  always_comb begin
    w_sel = r_csum;
    if (r_idx == 9'd0)        w_sel = HDR;
    else if (r_idx == 9'd1)   w_sel = r_len;
    else if (r_idx < w_len2)  w_sel = w_rdata;
  end

  ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= COLLECT;
      r_bcnt    <= '0;
      r_wptr    <= '0;
      r_len     <= '0;
      r_csum    <= '0;
      r_shift   <= '0;
      r_tx_data <= '0;
      r_idx     <= '0;
      r_trmt    <= 1'b0;
      r_ovf     <= 1'b0;
      r_ovf_frm <= 1'b0;
    end else begin
      r_trmt <= 1'b0;
      case (r_state)
        COLLECT: if (bit_vld) begin
          if (w_full) begin
            r_ovf     <= 1'b1;
            r_ovf_frm <= 1'b1;
          end else if (r_bcnt == 3'd7) begin
            r_shift <= '0;
            r_wptr  <= r_wptr + 8'd1;
            r_bcnt  <= '0;
          end else begin
            r_shift[r_bcnt] <= bit_in;
            r_bcnt          <= r_bcnt + 3'd1;
          end
          if (bit_last) r_state <= FLUSH;
        end
        FLUSH: begin
          if (r_bcnt != 3'd0 && !w_full) begin
            r_wptr <= r_wptr + 8'd1;
            r_len  <= r_wptr + 8'd1;
          end else begin
            r_len  <= r_wptr;
          end
          r_idx   <= '0;
          r_csum  <= '0;
          r_state <= FETCH;
        end
        FETCH: r_state <= SEND;
        SEND: begin
          r_tx_data <= w_sel;
          r_trmt    <= 1'b1;
          if (r_idx != 9'd0 && r_idx < w_len2) r_csum <= r_csum ^ w_sel;
          // ovf reports the previous frame until this header goes out.
          if (r_idx == 9'd0) begin
            r_ovf     <= r_ovf_frm;
            r_ovf_frm <= 1'b0;
          end
          r_state <= WAIT;
        end
        WAIT: if (tx_done) begin
          if (r_idx == w_len2) begin
            r_wptr  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_state <= COLLECT;
          end else begin
            r_idx   <= r_idx + 9'd1;
            r_state <= FETCH;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign bit_rdy    = (r_state == COLLECT);
  assign busy       = (r_state != COLLECT);
  assign trmt       = r_trmt;
  assign tx_data    = r_tx_data;
  assign ovf        = r_ovf;
  assign frame_sent = (r_state == WAIT) && tx_done && (r_idx == w_len2);

endmodule

// File: tb/tb_cnn_result_tx.sv
// Bench for cnn_result_tx: two instances (128-byte and 4-byte buffers),
// random bit frames checked against a byte-level frame model.
module tb_cnn_result_tx;
  import cnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] bit_vld, bit_in, bit_last, bit_rdy, trmt, tx_done, busy, ovf, frame_sent;
  logic [7:0] tx_data [2];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         maxb [2] = '{128, 4};
  logic [7:0] hdrs [2] = '{8'hA5, 8'h3C};
  bit         m_ovf [2] = '{1'b0, 1'b0};

  cnn_result_tx #(.MAX_BYTES(128)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld[0]), .bit_in(bit_in[0]),
    .bit_last(bit_last[0]), .bit_rdy(bit_rdy[0]), .trmt(trmt[0]),
    .tx_data(tx_data[0]), .tx_done(tx_done[0]), .busy(busy[0]),
    .ovf(ovf[0]), .frame_sent(frame_sent[0])
  );

  cnn_result_tx #(.MAX_BYTES(4), .HDR(8'h3C)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld[1]), .bit_in(bit_in[1]),
    .bit_last(bit_last[1]), .bit_rdy(bit_rdy[1]), .trmt(trmt[1]),
    .tx_data(tx_data[1]), .tx_done(tx_done[1]), .busy(busy[1]),
    .ovf(ovf[1]), .frame_sent(frame_sent[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame as the UART should see it, derived from the bit list alone.
  task automatic build(input bit b[$], input int mx, input logic [7:0] hdr,
                       output logic [7:0] f[$], output bit ov);
    int         nb;
    logic [7:0] by, cs;
    f.delete();
    ov = (b.size() > mx * 8);
    nb = (b.size() + 7) / 8;
    if (nb > mx) nb = mx;
    f.push_back(hdr);
    f.push_back(8'(nb));
    cs = 8'(nb);
    for (int i = 0; i < nb; i++) begin
      by = '0;
      for (int j = 0; j < 8; j++)
        if (i * 8 + j < b.size()) by[j] = b[i * 8 + j];
      f.push_back(by);
      cs ^= by;
    end
    f.push_back(cs);
  endtask

  task automatic rand_bits(input int n, output bit q[$]);
    q.delete();
    repeat (n) q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bit_vld = '0; bit_in = '0; bit_last = '0; tx_done = '0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // bp_k: byte index whose tx_done is held off 100 cycles; abort_k: reset during that byte's WAIT.
  task automatic run_frame(input int s, input bit b[$], input int bp_k, input int abort_k);
    logic [7:0] f[$];
    bit         ov;
    int         cnt, hold;
    logic [7:0] held;
    build(b, maxb[s], hdrs[s], f, ov);
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      if (i == 0) chk("bit_rdy_idle", bit_rdy[s], 1);
      else        chk("ovf_collect", ovf[s], m_ovf[s]);
      bit_vld[s] = 1'b1; bit_in[s] = b[i]; bit_last[s] = (i == b.size() - 1);
      if (i >= maxb[s] * 8) m_ovf[s] = 1'b1;
    end
    @(negedge clk);
    bit_vld[s] = 1'b0; bit_last[s] = 1'b0;
    chk("ovf_last", ovf[s], m_ovf[s]);
    chk("busy_flush", busy[s], 1);
    chk("bit_rdy_flush", bit_rdy[s], 0);
    cnt = 0;
    while (!trmt[s] && cnt < 20) begin @(negedge clk); cnt++; end
    chk("hdr_latency", cnt, 3);
    if (!trmt[s]) begin do_reset(); return; end
    for (int k = 0; k < f.size(); k++) begin
      chk($sformatf("byte%0d", k), tx_data[s], f[k]);
      if (k == 0) begin
        m_ovf[s] = ov;
        chk("ovf_hdr", ovf[s], m_ovf[s]);
      end
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk("rst_trmt", trmt[s], 0);
        chk("rst_tx_data", tx_data[s], 0);
        chk("rst_busy", busy[s], 0);
        chk("rst_bit_rdy", bit_rdy[s], 1);
        chk("rst_ovf", ovf[s], 0);
        chk("rst_frame_sent", frame_sent[s], 0);
        m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      held = tx_data[s];
      hold = (k == bp_k) ? 100 : $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        if (k == bp_k) begin
          bit_vld[s] = 1'b1; bit_in[s] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("hold_trmt", trmt[s], 0);
        chk("hold_tx_data", tx_data[s], held);
        chk("hold_bit_rdy", bit_rdy[s], 0);
      end
      bit_vld[s] = 1'b0;
      tx_done[s] = 1'b1;
      #1;
      chk("frame_sent", frame_sent[s], (k == f.size() - 1));
      @(negedge clk);
      tx_done[s] = 1'b0;
      if (k == f.size() - 1) begin
        chk("end_busy", busy[s], 0);
        chk("end_bit_rdy", bit_rdy[s], 1);
      end else begin
        cnt = 0;
        while (!trmt[s] && cnt < 10) begin @(negedge clk); cnt++; end
        chk("trmt_gap", cnt, 2);
        if (!trmt[s]) begin do_reset(); return; end
      end
    end
  endtask

  initial begin
    bit q[$];
    rst_n = 1'b0;
    bit_vld = '0; bit_in = '0; bit_last = '0; tx_done = '0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_trmt", trmt[s], 0);
      chk("reset_tx_data", tx_data[s], 0);
      chk("reset_busy", busy[s], 0);
      chk("reset_ovf", ovf[s], 0);
      chk("reset_frame_sent", frame_sent[s], 0);
      chk("reset_bit_rdy", bit_rdy[s], 1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    q = '{1,0,0,0,0,0,0,0, 1,1,1,1,0,0,0,0};
    run_frame(0, q, -1, -1);
    q = '{1,1,1};
    run_frame(0, q, -1, -1);
    rand_bits(676, q);
    run_frame(0, q, -1, -1);
    rand_bits(20, q);
    run_frame(0, q, 2, -1);
    rand_bits(40, q);
    run_frame(1, q, -1, -1);
    rand_bits(10, q);
    run_frame(1, q, -1, -1);
    rand_bits(24, q);
    run_frame(0, q, -1, 3);
    rand_bits(13, q);
    run_frame(0, q, -1, -1);
    for (int r = 0; r < 4; r++) begin
      rand_bits($urandom_range(1, 60), q);
      run_frame(r % 2, q, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
